// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// Holds the FSM state encoding and the default datapath width.
package serial_addsub_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_addsub_full_adder.sv
// One-bit full adder cell shared by every serial step.
// Purely combinational.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one bit per clock through a single cell.
// Results are published only in DONE so sum never shows partial shifts.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             c_msb;
    logic             fa_s;
    logic             fa_c;

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            c_msb  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b_in;
                        carry <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {fa_s, res_sr[WIDTH-1:1]};
                    carry  <= fa_c;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // carry entering the MSB cell, needed for overflow
                        c_msb <= carry;
                        state <= DONE;
                    end
                end
                DONE: begin
                    sum   <= res_sr;
                    cout  <= carry;
                    ovf   <= c_msb ^ carry;
                    zero  <= (res_sr == '0);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: arithmetic reference model,
// per-cycle output compare, directed corner cases and random traffic.
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b_in;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b_in  (b_in),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .zero  (zero)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [W:0] add_of(input logic [W-1:0] x,
                                          input logic [W-1:0] y,
                                          input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ovf_of(input logic [W-1:0] x,
                                    input logic [W-1:0] y,
                                    input logic c);
        logic [W:0] r;
        r = add_of(x, y, c);
        return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    endfunction

    // reference model: an op accepted in idle completes W+1 edges later
    logic         m_busy, m_done, m_cout, m_ovf, m_zero;
    logic [W-1:0] m_sum;
    logic [W:0]   op_res;
    logic         op_ovf;
    logic         pend;
    int           cyc = 0;
    int           done_at = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend   <= 1'b0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
            m_zero <= 1'b1;
        end else begin
            cyc    <= cyc + 1;
            m_done <= 1'b0;
            if (pend && cyc == done_at) begin
                pend   <= 1'b0;
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_sum  <= op_res[W-1:0];
                m_cout <= op_res[W];
                m_ovf  <= op_ovf;
                m_zero <= (op_res[W-1:0] == '0);
            end else if (!pend && start) begin
                pend    <= 1'b1;
                m_busy  <= 1'b1;
                done_at <= cyc + W + 1;
                op_res  <= add_of(a, b_in, sub);
                op_ovf  <= ovf_of(a, b_in, sub);
            end
        end
    end

    bit en_cmp = 1'b0;
    int ndone = 0;
    int dq[$];

    always @(negedge clk) begin
        if (done) begin
            ndone++;
            dq.push_back(cyc);
        end
        if (en_cmp) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("sum",  32'(sum),  32'(m_sum));
            chk("cout", 32'(cout), 32'(m_cout));
            chk("ovf",  32'(ovf),  32'(m_ovf));
            chk("zero", 32'(zero), 32'(m_zero));
        end
    end

    task automatic go(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic c);
        start = 1'b1;
        a     = x;
        b_in  = y;
        sub   = c;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    // returns at a negedge with done high (or after a timeout)
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!done) chk("timeout", 32'(done), 32'(1));
    endtask

    task automatic directed(input string name, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic c,
                            input logic [W-1:0] es, input logic ec,
                            input logic eo, input logic ez);
        int lat;
        go(x, y, c);
        wait_done(lat);
        chk({name, "_lat"},   32'(lat),   32'(W + 1));
        chk({name, "_sum"},   32'(sum),   32'(es));
        chk({name, "_cout"},  32'(cout),  32'(ec));
        chk({name, "_ovf"},   32'(ovf),   32'(eo));
        chk({name, "_zero"},  32'(zero),  32'(ez));
        chk({name, "_model"}, 32'(m_sum), 32'(es));
        @(posedge clk);
        #2;
    endtask

    initial begin
        int lat;
        int n0;
        logic [W-1:0] rb;
        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b_in  = '0;
        sub   = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_sum",  32'(sum),  32'(0));
        chk("rst_zero", 32'(zero), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        en_cmp = 1'b1;

        directed("sub5m3", 8'h05, 8'hFC, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
        directed("ovf",    8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        directed("wrap",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // restart attempt mid-run must be ignored
        n0 = ndone;
        go(8'h12, 8'h34, 1'b0);
        repeat (2) @(posedge clk);
        #2 start = 1'b1;
        a = 8'hAA;
        b_in = 8'h55;
        sub = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        wait_done(lat);
        chk("ign_sum", 32'(sum), 32'(8'h46));
        repeat (3) @(posedge clk);
        #2;
        chk("ign_ndone", 32'(ndone - n0), 32'(1));

        // abort by reset mid-run
        go(8'h33, 8'h44, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_sum",  32'(sum),  32'(0));
        chk("abort_zero", 32'(zero), 32'(1));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_cout", 32'(cout), 32'(0));
        chk("abort_ovf",  32'(ovf),  32'(0));
        @(posedge clk);
        #2 rst = 1'b0;
        n0 = ndone;
        repeat (W + 4) @(posedge clk);
        #2;
        chk("abort_nodone", 32'(ndone - n0), 32'(0));
        directed("post_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);

        // start held high: one op every W+2 cycles
        dq.delete();
        start = 1'b1;
        for (int k = 0; k < 5 * (W + 2); k++) begin
            a    = 8'($urandom);
            b_in = 8'($urandom);
            sub  = 1'($urandom);
            @(posedge clk);
            #2;
        end
        start = 1'b0;
        repeat (W + 3) @(posedge clk);
        #2;
        chk("b2b_count", 32'(dq.size()), 32'(5));
        for (int k = 1; k < dq.size(); k++)
            chk("b2b_space", 32'(dq[k] - dq[k-1]), 32'(W + 2));

        // random traffic
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #2;
            rb = 8'($urandom);
            sub = 1'($urandom);
            go(8'($urandom), sub ? ~rb : rb, sub);
            wait_done(lat);
            @(posedge clk);
            #2;
        end

        repeat (3) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, a request to begin an operation.
REQ-005 SHALL have port a, input, WIDTH, operand A.
REQ-006 SHALL have port b_in, input, WIDTH, operand B as delivered by the upstream conditional-complement stage (already inverted when subtracting).
REQ-007 SHALL have port sub, input, 1, the subtract flag; it is the carry-in and is 1 when b_in is inverted.
REQ-008 SHALL have port busy, output, 1, high while an operation is in progress (states RUN and DONE).
REQ-009 SHALL have port done, output, 1, a one-cycle pulse that marks the result as valid.
REQ-010 SHALL have port sum, output, WIDTH, the registered result.
REQ-011 SHALL have port cout, output, 1, the carry out of the MSB.
REQ-012 SHALL have port ovf, output, 1, two's-complement overflow: carry into the MSB XOR carry out of the MSB.
REQ-013 SHALL have port zero, output, 1, high when sum == 0.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-015 In IDLE with start=1, SHALL on that edge latch a and b_in into shift registers, load carry <= sub, clear the bit counter and enter RUN.
REQ-016 SHALL ignore start while in RUN or DONE; latched operands SHALL NOT change.
REQ-017 In RUN, each cycle SHALL add the operand LSBs plus carry through one full-adder cell, shift the sum bit into the result MSB, shift both operands right and update carry.
REQ-018 SHALL leave RUN after exactly WIDTH RUN cycles (counter == WIDTH-1) and enter DONE.
REQ-019 SHALL capture the carry-in of the final (MSB) bit on the last RUN cycle, to form ovf.
REQ-020 In DONE, SHALL assert done=1 for exactly one cycle, present sum/cout/ovf/zero, and return to IDLE.
REQ-021 Latency: with start sampled at edge N, done SHALL be high in the cycle following edge N+WIDTH+1.
REQ-022 sum, cout, ovf and zero SHALL hold their values until the next DONE; intermediate shift values SHALL NOT be visible on sum.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH; the result is a + b_in + sub.
REQ-024 start asserted in the same cycle as DONE SHALL be ignored; a new start is accepted only in IDLE.

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE and clear busy, done, sum, cout, ovf, the counter, the carry and the shift registers.
REQ-026 zero SHALL read 1 during and after reset, consistent with sum=0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after reset is deasserted SHALL begin a fresh operation.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-029 Counter width SHALL be $clog2(WIDTH) bits, minimum 1.
REQ-030 The one-bit adder SHALL be a separate sub-module, full_adder (a, b, cin -> s, cout), instantiated once.

Verification
REQ-031 a=0x05, b_in=0xFC, sub=1 -> done at cycle 10 after start; sum=0x02, cout=1, ovf=0, zero=0.
REQ-032 a=0x7F, b_in=0x01, sub=0 -> sum=0x80, cout=0, ovf=1.
REQ-033 a=0xFF, b_in=0x01, sub=0 -> sum=0x00, cout=1, ovf=0, zero=1.
REQ-034 start re-pulsed with different operands at cycle 3 of RUN -> ignored; result matches the first operands; exactly one done pulse.
REQ-035 rst pulsed at cycle 4 of RUN -> all outputs 0 (zero=1) immediately, no done; the next start with a=0x10, b_in=0x20, sub=0 -> sum=0x30.
REQ-036 Back-to-back: start held high continuously -> operations spaced WIDTH+2 cycles apart, one done per operation.
